// File: rtl/regfile_2r1w_if.sv
// regfile_2r1w_if: port bundle for the 2-read/1-write register file.
// The decode side drives addresses and write data; the file returns read data and busy.

interface regfile_2r1w_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_a;
    logic [WIDTH-1:0]  rd_data_b;
    logic              clr_req;
    logic              busy;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr_a,
        output rd_addr_b,
        output clr_req,
        input  rd_data_a,
        input  rd_data_b,
        input  busy
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr_a,
        input  rd_addr_b,
        input  clr_req,
        output rd_data_a,
        output rd_data_b,
        output busy
    );

endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file, two registered read ports,
// one write port with same-cycle forwarding, optional zero reg 0, bulk clear.

module regfile_2r1w #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int ZERO_REG0 = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_2r1w_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
    localparam bit                ZERO_C  = (ZERO_REG0 != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              busy_q;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd_a_q;
    logic [WIDTH-1:0]  rd_b_q;

    logic              wr_ok;
    logic              a_ok;
    logic              b_ok;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

    // Qualify the write and both read addresses against range and reg 0.
    always_comb begin
        wr_ok = bus.wr_en
              && (state == IDLE)
              && ({1'b0, bus.wr_addr} < DEPTH_C)
              && !(ZERO_C && (bus.wr_addr == '0));
        a_ok  = ({1'b0, bus.rd_addr_a} < DEPTH_C)
              && !(ZERO_C && (bus.rd_addr_a == '0));
        b_ok  = ({1'b0, bus.rd_addr_b} < DEPTH_C)
              && !(ZERO_C && (bus.rd_addr_b == '0));
    end

    // Read selection: zero when out of range, forwarded data on a hit, else storage.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        if (a_ok) begin
            if (wr_ok && (bus.wr_addr == bus.rd_addr_a)) begin
                sel_a = bus.wr_data;
            end else begin
                sel_a = mem[bus.rd_addr_a];
            end
        end
        if (b_ok) begin
            if (wr_ok && (bus.wr_addr == bus.rd_addr_b)) begin
                sel_b = bus.wr_data;
            end else begin
                sel_b = mem[bus.rd_addr_b];
            end
        end
    end

    // Clear sequencer: one register per edge, busy registered alongside state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST_C) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage: clear engine owns the array while busy, otherwise accepted writes land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= sel_a;
            rd_b_q <= sel_b;
        end
    end

    assign bus.rd_data_a = rd_a_q;
    assign bus.rd_data_b = rd_b_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: three register files (8 regs, 8 regs with zero reg 0, 6 regs)
// share one stimulus stream and are checked against an array reference model.

module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [2:0]  ra = '0;
    logic [2:0]  rb = '0;
    logic        clr_req = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_2r1w_if #(.WIDTH(16), .ADDR_W(3)) if0 ();
    regfile_2r1w_if #(.WIDTH(16), .ADDR_W(3)) if1 ();
    regfile_2r1w_if #(.WIDTH(16), .ADDR_W(3)) if2 ();

    assign if0.wr_en     = wr_en;
    assign if0.wr_addr   = wr_addr;
    assign if0.wr_data   = wr_data;
    assign if0.rd_addr_a = ra;
    assign if0.rd_addr_b = rb;
    assign if0.clr_req   = clr_req;
    assign if1.wr_en     = wr_en;
    assign if1.wr_addr   = wr_addr;
    assign if1.wr_data   = wr_data;
    assign if1.rd_addr_a = ra;
    assign if1.rd_addr_b = rb;
    assign if1.clr_req   = clr_req;
    assign if2.wr_en     = wr_en;
    assign if2.wr_addr   = wr_addr;
    assign if2.wr_data   = wr_data;
    assign if2.rd_addr_a = ra;
    assign if2.rd_addr_b = rb;
    assign if2.clr_req   = clr_req;

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ZERO_REG0(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );
    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .ZERO_REG0(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );
    regfile_2r1w #(.WIDTH(16), .DEPTH(6), .ZERO_REG0(0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave)
    );

    logic [15:0] oa [3];
    logic [15:0] ob [3];
    logic        obsy [3];

    assign oa[0]   = if0.rd_data_a;
    assign ob[0]   = if0.rd_data_b;
    assign obsy[0] = if0.busy;
    assign oa[1]   = if1.rd_data_a;
    assign ob[1]   = if1.rd_data_b;
    assign obsy[1] = if1.busy;
    assign oa[2]   = if2.rd_data_a;
    assign ob[2]   = if2.rd_data_b;
    assign obsy[2] = if2.busy;

    // Reference model: register contents plus "clear cycles remaining".
    int          dep [3] = '{8, 8, 6};
    bit          zr  [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] mem [3][8];
    int          left [3];
    logic [15:0] ea [3];
    logic [15:0] eb [3];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) mem[k][i] = '0;
            left[k] = 0;
            ea[k] = '0;
            eb[k] = '0;
        end
    endtask

    function automatic logic [15:0] pick(input int k, input logic [2:0] a,
                                         input bit acc);
        if (int'(a) >= dep[k] || (zr[k] && a == 3'd0)) return 16'h0;
        if (acc && a == wr_addr) return wr_data;
        return mem[k][a];
    endfunction

    task automatic model_edge();
        bit acc;
        for (int k = 0; k < 3; k++) begin
            acc = wr_en && left[k] == 0 && int'(wr_addr) < dep[k]
                  && !(zr[k] && wr_addr == 3'd0);
            ea[k] = pick(k, ra, acc);
            eb[k] = pick(k, rb, acc);
            if (acc) mem[k][wr_addr] = wr_data;
            if (left[k] > 0) begin
                mem[k][dep[k] - left[k]] = '0;
                left[k]--;
            end else if (clr_req) begin
                left[k] = dep[k];
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.rd_a", k), 32'(oa[k]), 32'(ea[k]));
            chk($sformatf("u%0d.rd_b", k), 32'(ob[k]), 32'(eb[k]));
            chk($sformatf("u%0d.busy", k), 32'(obsy[k]), 32'(left[k] != 0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    int c0;
    int c2;

    initial begin
        model_reset();

        // Reset with random inputs.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'($urandom);
            wr_addr = 3'($urandom);
            wr_data = 16'($urandom);
            ra = 3'($urandom);
            rb = 3'($urandom);
            clr_req = 1'($urandom);
            tick();
        end
        chk("rst.rd_a", 32'(oa[0]), 32'h0);
        chk("rst.busy", 32'(obsy[0]), 32'h0);
        wr_en = 1'b0;
        clr_req = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i);
            rb = 3'(7 - i);
            tick();
        end

        // Plain write then read.
        wr(3'd3, 16'hA5A5);
        rb = 3'd4;
        tick();
        wr_en = 1'b0;
        ra = 3'd3;
        tick();
        chk("wr3.rd_a", 32'(oa[0]), 32'hA5A5);
        chk("rd4.rd_b", 32'(ob[0]), 32'h0);

        // Forwarding to both ports.
        wr(3'd5, 16'h1234);
        ra = 3'd5;
        rb = 3'd5;
        tick();
        chk("fwd.a", 32'(oa[0]), 32'h1234);
        chk("fwd.b", 32'(ob[0]), 32'h1234);
        chk("fwd6.a", 32'(oa[2]), 32'h1234);

        // Zero register 0.
        wr(3'd0, 16'hFFFF);
        ra = 3'd0;
        rb = 3'd0;
        tick();
        chk("z0.fwd.a", 32'(oa[1]), 32'h0);
        chk("z0.fwd.b", 32'(ob[1]), 32'h0);
        chk("nz0.fwd.a", 32'(oa[0]), 32'hFFFF);
        wr_en = 1'b0;
        tick();
        chk("z0.rd", 32'(oa[1]), 32'h0);
        wr(3'd1, 16'h0101);
        ra = 3'd1;
        tick();
        wr_en = 1'b0;
        tick();
        chk("z1.rd", 32'(oa[1]), 32'h0101);

        // Fill, then bulk clear with a dropped write and ignored re-request.
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 16'(16'h0011 * (i + 1)));
            tick();
        end
        wr_en = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        c0 = obsy[0] ? 1 : 0;
        c2 = obsy[2] ? 1 : 0;
        for (int k = 0; k < 12; k++) begin
            ra = 3'(k % 8);
            rb = 3'(7 - (k % 8));
            wr_en = (k == 1);
            wr_addr = 3'd2;
            wr_data = 16'hBEEF;
            clr_req = (k == 3);
            tick();
            if (obsy[0]) c0++;
            if (obsy[2]) c2++;
        end
        wr_en = 1'b0;
        clr_req = 1'b0;
        chk("clr.len8", 32'(c0), 32'd8);
        chk("clr.len6", 32'(c2), 32'd6);
        ra = 3'd2;
        tick();
        chk("clr.reg2", 32'(oa[0]), 32'h0);

        // Out-of-range addresses on the 6-deep file.
        wr(3'd7, 16'h7777);
        ra = 3'd7;
        rb = 3'd6;
        tick();
        chk("d6.fwd7", 32'(oa[2]), 32'h0);
        chk("d6.rd6", 32'(ob[2]), 32'h0);
        chk("d8.fwd7", 32'(oa[0]), 32'h7777);
        wr_en = 1'b0;
        tick();
        chk("d6.rd7", 32'(oa[2]), 32'h0);

        // Refill, then reset in the middle of a clear.
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 16'(16'h0100 + i));
            tick();
        end
        wr_en = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.busy6", 32'(obsy[2]), 32'h0);
        chk("midrst.busy8", 32'(obsy[0]), 32'h0);
        check_all();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i);
            rb = 3'(i);
            tick();
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            wr_en = 1'($urandom);
            wr_addr = 3'($urandom);
            wr_data = 16'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
            clr_req = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file with two independent registered read ports and one write port. It replaces the fixed 8×16 combinational register-select mux in the datapath. Beyond plain selection it adds:
- write-to-read forwarding;
- an optional hardwired-zero register 0;
- a sequenced bulk-clear engine with a busy indication.

It sits between the decode stage (addresses) and the ALU operand inputs.

## Interface
Parameters:
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers; any value ≥ 2, need not be a power of two
- ZERO_REG0, 0, when 1 register 0 always reads 0 and ignores writes
- ADDR_W (localparam), clog2(DEPTH), address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write register index
- wr_data  in  WIDTH  write data
- rd_addr_a  in  ADDR_W  port A read index
- rd_addr_b  in  ADDR_W  port B read index
- rd_data_a  out  WIDTH  port A read data, registered
- rd_data_b  out  WIDTH  port B read data, registered
- clr_req  in  1  request bulk clear of all registers
- busy  out  1  clear in progress; writes and clear requests ignored

## Operation
Reset (rst_n low, asynchronous):
- All registers, rd_data_a and rd_data_b go to 0.
- busy goes to 0, state goes to IDLE and the clear counter goes to 0.

Write:
- Accepted on a rising edge when wr_en=1, busy=0 and wr_addr < DEPTH.
- Effect: reg[wr_addr] ← wr_data.
- Dropped silently when busy=1, when wr_addr ≥ DEPTH, or when ZERO_REG0=1 and wr_addr=0.

Read (each port independent, identical rules):
- On every edge, rd_data_x ← selected value for rd_addr_x.
- Selected value is 0 if rd_addr_x ≥ DEPTH, or if ZERO_REG0=1 and rd_addr_x=0.
- Otherwise it is wr_data, if a write is accepted in the same cycle to the same address (forwarding).
- Otherwise it is reg[rd_addr_x].
- Both ports may address the same register, and both may forward at once.

Clear state machine, two states:
- IDLE: clr_req=1 sampled on an edge → CLEAR, cnt ← 0.
- CLEAR: each edge performs reg[cnt] ← 0 and cnt ← cnt+1. On the edge where cnt = DEPTH−1 the last register is cleared and the state returns to IDLE.
- busy = (state == CLEAR).
- clr_req while in CLEAR is ignored. It is not queued.
- clr_req and an accepted wr_en in the same IDLE cycle: the write is performed, then clearing starts and overwrites it.
- Reads during CLEAR continue. Registers not yet cleared return their old contents; cleared ones return 0. No forwarding occurs because no write is accepted.

Width and arithmetic:
- cnt is ADDR_W bits and never exceeds DEPTH−1.
- Address comparisons are unsigned.

## Timing
- Read latency: 1 cycle. rd_addr presented in cycle N is visible on rd_data from edge N+1.
- Write: visible in storage after the accepting edge. A read of the same address issued in the same cycle returns the new data via forwarding, so read-after-write has 0 cycles of penalty.
- Clear:
  - clr_req sampled at edge E0 → busy=1 after E0.
  - Registers 0..DEPTH−1 are cleared at edges E1..E_DEPTH.
  - busy=0 after E_DEPTH.
  - busy is high for exactly DEPTH cycles.
  - The first write that can be accepted is sampled at E_DEPTH+1.
- Reset mid-clear: state returns to IDLE at once, all registers 0, busy=0.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 with random inputs → rd_data_a=rd_data_b=0 and busy=0. After release, reading every address returns 0.
- Write/read (WIDTH=16, DEPTH=8):
  - Write 16'hA5A5 to reg 3; next cycle set rd_addr_a=3 → rd_data_a=16'hA5A5 one edge later.
  - Port B reading reg 4 returns 0.
- Forwarding: in one cycle set wr_en=1, wr_addr=5, wr_data=16'h1234, rd_addr_a=rd_addr_b=5 → both read ports show 16'h1234 after that edge.
- ZERO_REG0=1:
  - Write 16'hFFFF to reg 0 → reads of reg 0 return 0, including the forwarding case.
  - Write to reg 1 works normally.
- Clear:
  - Fill regs 0..7 with 16'h0011·(i+1), then pulse clr_req → busy high for 8 cycles.
  - Port A sweeping addresses shows each register reach 0 in order.
  - A write of 16'hBEEF to reg 2 during busy is dropped, so reg 2 reads 0.
  - A second clr_req during busy has no effect: busy falls after exactly 8 cycles.
- Non-power-of-two (DEPTH=6, ADDR_W=3):
  - A write to address 7 has no effect.
  - A read of address 6 or 7 returns 0.
  - A clear completes in 6 cycles.
  - Asserting rst_n=0 at clear cycle 3 → busy=0 immediately and all reads return 0.
